// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants (rounding modes, FP32 bias, fflags bit positions)
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [7:0] FP32_BIAS = 8'd127;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

endpackage

// File: rtl/fp_round_inc.sv
// fp_round_inc: IEEE-754 round-increment decision from lsb/guard/sticky and rounding mode
module fp_round_inc
    import fpu_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       s,
    output logic       inc,
    output logic       inexact
);

    // unlisted encodings fall through to round-to-nearest-even
    always_comb begin
        inexact = g | s;
        inc = (rm == RM_RTZ) ? 1'b0 :
              (rm == RM_RDN) ? sign & inexact :
              (rm == RM_RUP) ? !sign & inexact :
              (rm == RM_RMM) ? g :
                               g & (s | lsb);
    end

endmodule

// File: rtl/int_to_fp_postnorm.sv
// int_to_fp_postnorm: two-stage I2F post-normalization, rounding and FP32 packing
module int_to_fp_postnorm
    import fpu_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [62:0]      norm_int_i,
    input  logic [5:0]       lzc_i,
    input  logic             is_zero_i,
    input  logic             sign_i,
    input  logic [2:0]       rm_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      result_o,
    output logic [4:0]       fflags_o,
    output logic [TAG_W-1:0] tag_o
);

    logic             s1_valid;
    logic [62:0]      s1_norm;
    logic [5:0]       s1_lzc;
    logic             s1_zero;
    logic             s1_sign;
    logic [2:0]       s1_rm;
    logic [TAG_W-1:0] s1_tag;

    logic        s2_load;
    logic        s1_adv;
    logic        inc;
    logic        inexact;
    logic [7:0]  exp_b;
    logic [30:0] rounded;
    logic [31:0] result_d;
    logic [4:0]  flags_d;

    assign s2_load    = !out_valid_o | out_ready_i;
    assign s1_adv     = s1_valid & s2_load;
    assign in_ready_o = !s1_valid | s1_adv;

    fp_round_inc u_round (
        .rm      (s1_rm),
        .sign    (s1_sign),
        .lsb     (s1_norm[40]),
        .g       (s1_norm[39]),
        .s       (|s1_norm[38:0]),
        .inc     (inc),
        .inexact (inexact)
    );

    // a mantissa carry out of the add ripples straight into the exponent field
    always_comb begin
        exp_b    = FP32_BIAS + 8'd63 - {2'b00, s1_lzc};
        rounded  = {exp_b, s1_norm[62:40]} + 31'(inc);
        result_d = s1_zero ? 32'h0 : {s1_sign, rounded};
        flags_d  = '0;
        flags_d[FF_NX] = !s1_zero & inexact;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_norm     <= '0;
            s1_lzc      <= '0;
            s1_zero     <= 1'b0;
            s1_sign     <= 1'b0;
            s1_rm       <= '0;
            s1_tag      <= '0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            fflags_o    <= '0;
            tag_o       <= '0;
        end else begin
            if (in_ready_o)
                s1_valid <= in_valid_i;
            if (in_ready_o & in_valid_i) begin
                s1_norm <= norm_int_i;
                s1_lzc  <= lzc_i;
                s1_zero <= is_zero_i;
                s1_sign <= sign_i;
                s1_rm   <= rm_i;
                s1_tag  <= tag_i;
            end
            if (s2_load)
                out_valid_o <= s1_valid;
            if (s1_adv) begin
                result_o <= result_d;
                fflags_o <= flags_d;
                tag_o    <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_int_to_fp_postnorm.sv
// tb_int_to_fp_postnorm: directed + randomized bench against an arithmetic I2F rounding model
module tb_int_to_fp_postnorm;

    typedef struct packed {
        logic [7:0]  tag;
        logic [4:0]  ff;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [62:0] norm_int_i = '0;
    logic [5:0]  lzc_i = '0;
    logic        is_zero_i = 1'b0;
    logic        sign_i = 1'b0;
    logic [2:0]  rm_i = '0;
    logic [7:0]  tag_i = '0;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;
    logic [7:0]  tag_o;

    logic bp_mode   = 1'b0;
    logic man_ready = 1'b1;
    logic rnd_ready = 1'b1;
    assign out_ready_i = bp_mode ? rnd_ready : man_ready;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t q[$];
    exp_t cur;

    int_to_fp_postnorm #(.TAG_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .norm_int_i  (norm_int_i),
        .lzc_i       (lzc_i),
        .is_zero_i   (is_zero_i),
        .sign_i      (sign_i),
        .rm_i        (rm_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .fflags_o    (fflags_o),
        .tag_o       (tag_o)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        rnd_ready = $urandom_range(0, 2) != 0;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // exact value = mag * 2^0; keep 24 significant bits and round the remainder
    function automatic logic [36:0] ref_fp(input logic [63:0] mag, input logic sgn, input logic [2:0] rm);
        int          e = 63;
        logic [63:0] q_m, r, half;
        logic        up;
        while (!mag[e]) e--;
        if (e <= 23) begin
            q_m  = mag << (23 - e);
            r    = 0;
            half = 1;
        end else begin
            q_m  = mag >> (e - 23);
            r    = mag - (q_m << (e - 23));
            half = 64'd1 << (e - 24);
        end
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = sgn && r != 0;
            3'd3:    up = !sgn && r != 0;
            3'd4:    up = r >= half;
            default: up = r > half || (r == half && q_m[0]);
        endcase
        q_m = q_m + 64'(up);
        if (q_m[24]) begin
            q_m = q_m >> 1;
            e++;
        end
        return {4'b0, r != 0, sgn, 8'(e + 127), q_m[22:0]};
    endfunction

    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (out_valid_o) begin
                if (q.size() == 0) check("stale_out", 64'(out_valid_o), 64'd0);
                else begin
                    check("out", 64'({tag_o, fflags_o, result_o}), 64'(q[0]));
                    if (out_ready_i) void'(q.pop_front());
                end
            end
            if (in_valid_i && in_ready_o) q.push_back(cur);
        end
    end

    task automatic send(input logic [63:0] mag, input logic zero, input logic sgn, input logic [2:0] rm,
                        input logic [7:0] tag, input logic [31:0] eres, input logic [4:0] eff);
        int lz  = 0;
        bit acc = 0;
        if (!zero) while (!mag[63 - lz]) lz++;
        norm_int_i = zero ? 63'({$urandom, $urandom}) : 63'(mag << lz);
        lzc_i      = 6'(lz);
        is_zero_i  = zero;
        sign_i     = sgn;
        rm_i       = rm;
        tag_i      = tag;
        cur        = '{tag, eff, eres};
        in_valid_i = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_rand(input logic [7:0] tag);
        int          w   = $urandom_range(1, 64);
        logic [63:0] mag = {$urandom, $urandom} >> (64 - w);
        logic        sgn = 1'($urandom);
        logic [2:0]  rm  = 3'($urandom_range(0, 7));
        logic [36:0] e;
        mag = mag | (64'd1 << (w - 1));
        if ($urandom_range(0, 15) == 0) send(64'd0, 1'b1, sgn, rm, tag, 32'h0, 5'h0);
        else begin
            e = ref_fp(mag, sgn, rm);
            send(mag, 1'b0, sgn, rm, tag, e[31:0], e[36:32]);
        end
    endtask

    task automatic drain();
        in_valid_i = 1'b0;
        bp_mode    = 1'b0;
        man_ready  = 1'b1;
        for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clk);
        check("drain", 64'(q.size()), 64'd0);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        check("rst_data", 64'({tag_o, fflags_o, result_o}), 64'd0);
        @(posedge clk);
        #1;

        send(64'd1, 1'b0, 1'b0, 3'd0, 8'd1, 32'h3F80_0000, 5'h0);
        in_valid_i = 1'b0;
        @(negedge clk);
        check("lat1", 64'(out_valid_o), 64'd0);
        @(negedge clk);
        check("lat2", 64'(out_valid_o), 64'd1);
        @(posedge clk);
        #1;
        send(64'd1,          1'b0, 1'b1, 3'd0, 8'd2, 32'hBF80_0000, 5'h0);
        send(64'h8000_0000,  1'b0, 1'b1, 3'd0, 8'd3, 32'hCF00_0000, 5'h0);
        send(64'h100_0001,   1'b0, 1'b0, 3'd0, 8'd4, 32'h4B80_0000, 5'h1);
        send(64'h100_0001,   1'b0, 1'b0, 3'd3, 8'd5, 32'h4B80_0001, 5'h1);
        send(64'h100_0001,   1'b0, 1'b0, 3'd1, 8'd6, 32'h4B80_0000, 5'h1);
        send(64'hFFFF_FFFF,  1'b0, 1'b0, 3'd0, 8'd7, 32'h4F80_0000, 5'h1);
        send(64'hFFFF_FFFF,  1'b0, 1'b0, 3'd2, 8'd8, 32'h4F7F_FFFF, 5'h1);
        send(64'd0,          1'b1, 1'b1, 3'd2, 8'd9, 32'h0,         5'h0);
        drain();

        man_ready = 1'b0;
        send_rand(8'd0);
        send_rand(8'd1);
        in_valid_i = 1'b0;
        @(negedge clk);
        check("bp_ready", 64'(in_ready_o), 64'd0);
        check("bp_accepts", 64'(q.size()), 64'd2);
        check("bp_tag", 64'(tag_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        man_ready = 1'b1;
        for (int t = 2; t < 6; t++) send_rand(8'(t));
        drain();

        bp_mode = 1'b1;
        for (int t = 0; t < 300; t++) begin
            send_rand(8'(t));
            if ($urandom_range(0, 3) == 0) begin
                in_valid_i = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        drain();

        bp_mode = 1'b1;
        for (int t = 0; t < 5; t++) send_rand(8'(8'h80 + t));
        rst        = 1'b1;
        in_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(out_valid_o), 64'd0);
        check("mid_rst_ready", 64'(in_ready_o), 64'd1);
        check("mid_rst_data", 64'({tag_o, fflags_o, result_o}), 64'd0);
        @(posedge clk);
        #1;
        for (int t = 0; t < 4; t++) send_rand(8'(8'hC0 + t));
        drain();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("idle_valid", 64'(out_valid_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/int_to_fp_postnorm.md
# int_to_fp_postnorm

Two-stage pipelined post-normalization and rounding stage for integer-to-FP32 conversion (I2F). It consumes the normalized mantissa, leading-zero count, zero flag and sign produced by the I2F prenorm stage, and computes the biased exponent. It applies the requested IEEE-754 rounding mode and packs the FP32 result with exception flags. Valid/ready handshakes on both sides let it sit directly in the FPU result path under back-pressure.

## Interface
- `TAG_W`, 8: width of the opaque tag (warp/register id) carried alongside each operation.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid_i` input 1: operation present on the inputs.
- `in_ready_o` output 1: stage can accept this cycle.
- `norm_int_i` input 63: prenorm mantissa with the leading 1 removed; bit 62 is the first fraction bit.
- `lzc_i` input 6: leading-zero count of the 64-bit magnitude.
- `is_zero_i` input 1: source integer was zero.
- `sign_i` input 1: result sign.
- `rm_i` input 3: rounding mode. RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4. Encodings 5–7 are treated as RNE.
- `tag_i` input TAG_W: passed through unchanged.
- `out_valid_o` output 1: result valid.
- `out_ready_i` input 1: consumer accepts the result.
- `result_o` output 32: FP32 result.
- `fflags_o` output 5: {NV,DZ,OF,UF,NX}.
- `tag_o` output TAG_W: tag of the result.

## Operation
- Stage S1 registers the accepted inputs. Between S1 and S2 is the rounding logic. Stage S2 registers the packed result, flags and tag.
- Exponent: `exp = 127 + (63 − lzc)`, 8-bit. The maximum value is 190, so the exponent never overflows; OF and UF are always 0.
- Mantissa: `m = norm[62:40]`, guard `g = norm[39]`, sticky `s = |norm[38:0]`, `lsb = norm[40]`.
- Round-increment decision `inc`:
  - RNE: `g & (s | lsb)`
  - RTZ: 0
  - RDN: `sign & (g | s)`
  - RUP: `!sign & (g | s)`
  - RMM: `g`
- Rounding: `{exp,m} + inc` is computed as a 31-bit add, so a mantissa carry increments the exponent.
- `NX = g | s`. NV and DZ are always 0.
- `is_zero_i = 1`: result is `32'h0000_0000` (+0 in every mode) and fflags are 0.
- `result_o = {sign, exp_r, m_r}`.

## Timing
- Latency: 2 cycles from input handshake to `out_valid_o`, with no stall. Throughput is 1 per cycle.
- Each stage holds a valid bit.
  - S2 loads when `!s2_valid | out_ready_i`.
  - S1 loads when `!s1_valid | s1_adv`, where `s1_adv = s1_valid & (!s2_valid | out_ready_i)`.
  - `in_ready_o = !s1_valid | s1_adv`. This is combinational from `out_ready_i`; there is no combinational path from `in_valid_i`.
- A transfer occurs on `valid & ready` at the rising edge. While `out_valid_o = 1 & out_ready_i = 0`, `result_o`, `fflags_o` and `tag_o` are held stable.
- Simultaneous S2 drain and S1 advance in the same cycle is lossless. Full pipe plus stall holds 2 operations with `in_ready_o = 0`.
- Reset clears both valid bits, and `out_valid_o = 0` in the cycle after `rst` is sampled high. In-flight operations are discarded. Data registers reset to 0, so `result_o`, `fflags_o` and `tag_o` are 0 after reset.
- `in_ready_o = 1` from the first cycle after reset.

## Structure
- Shared package `fpu_pkg` holds:
  - rounding-mode constants `RM_RNE` through `RM_RMM`
  - `FP32_BIAS = 127`
  - fflags bit indices `FF_NV`, `FF_DZ`, `FF_OF`, `FF_UF`, `FF_NX`
- Sub-module `fp_round_inc`: purely combinational. Inputs are `rm`, `sign`, `lsb`, `g`, `s`; outputs are `inc` and `inexact`. It is reusable by the F2F and FMA rounding paths.
- The pipeline control and S1/S2 registers live in `int_to_fp_postnorm`.

## Test plan
- Signed int 1 (norm = 0, lzc = 63), RNE → `3F80_0000`, fflags = 0, result 2 cycles after accept.
- Signed −1 (sign = 1, norm = 0, lzc = 63) → `BF80_0000`. Signed −2^31 (lzc = 32) → `CF00_0000`, fflags = 0.
- 2^24+1 (lzc = 39, norm bit 39 set):
  - RNE → `4B80_0000`, NX = 1
  - RUP → `4B80_0001`
  - RTZ → `4B80_0000`
- Unsigned `FFFF_FFFF` (lzc = 32, norm = all ones in [62:32]), RNE → `4F80_0000` (mantissa carry into the exponent), NX = 1. Same input with RDN → `4F7F_FFFF`.
- `is_zero_i = 1` with sign = 1 under RDN → `0000_0000`, fflags = 0.
- Back-pressure:
  - Stream 6 ops with `out_ready_i` low for 4 cycles → `in_ready_o` drops after 2 accepts, with no loss or reordering, checked by tags 0–5.
  - Assert `rst` mid-stream → `out_valid_o = 0` next cycle, and no stale result appears afterwards.
